reg_load_sequencer: RTL and testbench

//  Shares one 8-bit load bus among NUM_REQ requesters writing a bank of NUM_REG 8-bit

---
 rtl/reg_seq_pkg.sv | 20 ++
 rtl/reg_load_sequencer_if.sv | 32 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/reg_load_sequencer.sv | 153 +++++++++++++++
 tb/tb_reg_load_sequencer.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_seq_pkg.sv
// Shared types and constants for the register-load sequencer: FSM state
// encoding, load bus width and an address-width helper.
package reg_seq_pkg;

  localparam int BUS_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    CLEAR  = 3'd4
  } state_t;

  // Bits needed to index n items; never less than one.
  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reg_load_sequencer_if.sv
// Requester/bank-facing signal bundle of the register-load sequencer.
// The sequencer takes the slave side; requesters and bench take the master side.
interface reg_load_sequencer_if
  import reg_seq_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_REG = 8,
  parameter int ADDR_W  = addr_w(NUM_REG)
);

  logic [NUM_REQ-1:0]        REQ;
  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR;
  logic [NUM_REQ*BUS_W-1:0]  REQ_DATA;
  logic                      CLR;
  logic [NUM_REQ-1:0]        ACK;
  logic                      ERR;
  logic [BUS_W-1:0]          BUS_D;
  logic [NUM_REG-1:0]        REG_CP;
  logic                      N_REG_MR;
  logic                      BUSY;

  modport master (
    output REQ, REQ_ADDR, REQ_DATA, CLR,
    input  ACK, ERR, BUS_D, REG_CP, N_REG_MR, BUSY
  );

  modport slave (
    input  REQ, REQ_ADDR, REQ_DATA, CLR,
    output ACK, ERR, BUS_D, REG_CP, N_REG_MR, BUSY
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after the
// pointer, wrapping, reported as one-hot grant plus binary index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin : arb
    int j;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr is always < NUM_REQ, so one wrap subtraction suffices
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!valid && req[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/reg_load_sequencer.sv
// Arbitrates one shared load bus among requesters writing a register bank:
// drives bus data, strobes the target register clock once, acks, and sequences bank clears.
module reg_load_sequencer
  import reg_seq_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int NUM_REG      = 8,
  parameter int SETUP_CYCLES = 1
) (
  input logic                 CP,
  input logic                 MR,
  reg_load_sequencer_if.slave bus
);

  localparam int ADDR_W = addr_w(NUM_REG);
  localparam int IDX_W  = addr_w(NUM_REQ);
  localparam int CNT_W  = addr_w(SETUP_CYCLES);

  state_t state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               load;
  logic [IDX_W-1:0]   ptr;
  logic               clr_pend;

  logic [NUM_REQ-1:0] arb_req, arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic [ADDR_W-1:0]  win_addr;
  logic [BUS_W-1:0]   win_data;

  logic [NUM_REQ-1:0] grant_oh;
  logic [IDX_W-1:0]   grant_idx;
  logic [ADDR_W-1:0]  addr_q;

  logic [NUM_REQ-1:0] ack_q;
  logic               err_q;
  logic [BUS_W-1:0]   bus_d_q;
  logic [NUM_REG-1:0] reg_cp_q;
  logic               n_reg_mr_q;
  logic               busy_q;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REG;
  endfunction

  function automatic logic [NUM_REG-1:0] strobe_vec(input logic [ADDR_W-1:0] a);
    return in_range(a) ? (NUM_REG'(1) << a) : '0;
  endfunction

  function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
  endfunction

  // While acking, the current winner's request is masked so a still-high
  // REQ cannot be served twice.
  assign arb_req = (state == HOLD) ? (bus.REQ & ~grant_oh) : bus.REQ;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (arb_req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign win_addr = bus.REQ_ADDR[int'(arb_idx)*ADDR_W +: ADDR_W];
  assign win_data = bus.REQ_DATA[int'(arb_idx)*BUS_W +: BUS_W];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.CLR || clr_pend) begin
          state_nx = CLEAR;
        end else if (arb_valid) begin
          state_nx = SETUP;
          cnt_nx   = '0;
          load     = 1'b1;
        end
      end
      SETUP: begin
        if (cnt == CNT_W'(SETUP_CYCLES - 1)) state_nx = STROBE;
        else                                 cnt_nx   = cnt + 1'b1;
      end
      STROBE: state_nx = HOLD;
      HOLD: begin
        // A clear raised during the transaction is taken through one IDLE cycle
        if (bus.CLR || clr_pend) begin
          state_nx = IDLE;
        end else if (arb_valid) begin
          state_nx = SETUP;
          cnt_nx   = '0;
          load     = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      CLEAR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= '0;
      clr_pend   <= 1'b0;
      ack_q      <= '0;
      err_q      <= 1'b0;
      bus_d_q    <= '0;
      reg_cp_q   <= '0;
      n_reg_mr_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (load) bus_d_q <= win_data;
      if (state == STROBE) ptr <= ptr_after(grant_idx);
      if (state_nx == CLEAR)
        clr_pend <= 1'b0;
      else if (bus.CLR && state != IDLE && state != CLEAR)
        clr_pend <= 1'b1;
      // Outputs are registered against the state being entered
      reg_cp_q   <= (state_nx == STROBE) ? strobe_vec(addr_q) : '0;
      ack_q      <= (state_nx == HOLD) ? grant_oh : '0;
      err_q      <= (state_nx == HOLD) && !in_range(addr_q);
      n_reg_mr_q <= (state_nx != CLEAR);
      busy_q     <= (state_nx != IDLE);
    end
  end

  always_ff @(posedge CP) begin
    if (load) begin
      grant_oh  <= arb_grant;
      grant_idx <= arb_idx;
      addr_q    <= win_addr;
    end
  end

  assign bus.ACK      = ack_q;
  assign bus.ERR      = err_q;
  assign bus.BUS_D    = bus_d_q;
  assign bus.REG_CP   = reg_cp_q;
  assign bus.N_REG_MR = n_reg_mr_q;
  assign bus.BUSY     = busy_q;

endmodule

// File: tb/tb_reg_load_sequencer.sv
// Scoreboard bench for reg_load_sequencer: directed loads push expected acks,
// a negedge monitor pops them on every ACK and keeps a register-bank model.
module tb_reg_load_sequencer;
  import reg_seq_pkg::*;

  localparam int NQ = 4;
  localparam int NR = 6;
  localparam int AW = addr_w(NR);

  logic CP = 1'b0;
  logic MR = 1'b1;
  always #5 CP = ~CP;

  reg_load_sequencer_if #(.NUM_REQ(NQ), .NUM_REG(NR)) bus ();

  reg_load_sequencer #(
    .NUM_REQ      (NQ),
    .NUM_REG      (NR),
    .SETUP_CYCLES (1)
  ) dut (
    .CP  (CP),
    .MR  (MR),
    .bus (bus)
  );

  typedef struct {
    logic [NQ-1:0] ack;
    logic          err;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } exp_t;

  exp_t expq[$];
  int   ack_cyc[$];
  int   posted[NQ] = '{default: 0};
  int   acked[NQ]  = '{default: 0};
  logic [AW-1:0] raddr[NQ];
  logic [7:0]    rdata[NQ];
  logic [7:0]    model[NR];

  int checks = 0;
  int passed = 0;
  int cycle  = 0;
  int strobes = 0;
  int s_addr  = 0;
  logic [7:0] s_data = 8'h00;
  exp_t e;

  always @(posedge CP) cycle++;

  // Each requester holds REQ while it has unacknowledged loads
  for (genvar i = 0; i < NQ; i++) begin : g_req
    assign bus.REQ[i]              = (posted[i] != acked[i]);
    assign bus.REQ_ADDR[i*AW +: AW] = raddr[i];
    assign bus.REQ_DATA[i*8 +: 8]   = rdata[i];
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycle);
  endfunction

  function automatic logic all_done();
    for (int i = 0; i < NQ; i++) if (posted[i] != acked[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge CP) begin
    if (!bus.N_REG_MR) begin
      for (int k = 0; k < NR; k++) model[k] = 8'h00;
      strobes = 0;
    end
    chk("invariants", {28'h0, $onehot0(bus.REG_CP), !(bus.REG_CP != '0 && !bus.N_REG_MR),
                       $onehot0(bus.ACK), !(bus.ERR && bus.ACK == '0)}, 32'hF);
    if (bus.REG_CP != '0) begin
      for (int k = 0; k < NR; k++) if (bus.REG_CP[k]) s_addr = k;
      s_data = bus.BUS_D;
      model[s_addr] = bus.BUS_D;
      strobes++;
    end
    if (bus.ACK != '0) begin
      for (int i = 0; i < NQ; i++) if (bus.ACK[i]) acked[i]++;
      ack_cyc.push_back(cycle);
      if (expq.size() == 0) begin
        chk("unexpected_ack", 32'(bus.ACK), 32'h0);
      end else begin
        e = expq.pop_front();
        chk("ack", 32'(bus.ACK), 32'(e.ack));
        chk("err", 32'(bus.ERR), 32'(e.err));
        if (e.err) begin
          chk("err_no_strobe", strobes, 0);
        end else begin
          chk("strobes", strobes, 1);
          chk("strobe_addr", s_addr, 32'(e.addr));
          chk("strobe_data", 32'(s_data), 32'(e.data));
          chk("bus_held", 32'(bus.BUS_D), 32'(e.data));
        end
      end
      strobes = 0;
    end
  end

  task automatic push(input int g, input logic [AW-1:0] a, input logic [7:0] d, input logic er);
    exp_t x;
    x.ack = NQ'(1) << g; x.err = er; x.addr = a; x.data = d;
    expq.push_back(x);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!all_done() && n < budget) begin
      @(negedge CP);
      n++;
    end
    chk({name, "_done"}, 32'(all_done()), 32'h1);
    repeat (2) @(negedge CP);
  endtask

  initial begin
    int c0, n0, n;
    bus.CLR = 1'b0;
    for (int i = 0; i < NQ; i++) begin raddr[i] = '0; rdata[i] = '0; end
    for (int k = 0; k < NR; k++) model[k] = 8'h00;

    // Reset
    MR = 1'b1;
    repeat (2) @(negedge CP);
    chk("rst_ack", 32'(bus.ACK), 0);
    chk("rst_err", 32'(bus.ERR), 0);
    chk("rst_bus_d", 32'(bus.BUS_D), 0);
    chk("rst_reg_cp", 32'(bus.REG_CP), 0);
    chk("rst_busy", 32'(bus.BUSY), 0);
    chk("rst_n_reg_mr", 32'(bus.N_REG_MR), 0);
    MR = 1'b0;
    @(negedge CP);
    chk("rel_n_reg_mr", 32'(bus.N_REG_MR), 1);
    chk("rel_busy", 32'(bus.BUSY), 0);

    // Fairness: all four requesting, requester 0 twice
    for (int i = 0; i < NQ; i++) begin raddr[i] = AW'(i); rdata[i] = 8'h10 + 8'(i); end
    push(0, 0, 8'h10, 0); push(1, 1, 8'h11, 0); push(2, 2, 8'h12, 0);
    push(3, 3, 8'h13, 0); push(0, 0, 8'h10, 0);
    n0 = ack_cyc.size();
    c0 = cycle;
    posted[0] += 2; posted[1]++; posted[2]++; posted[3]++;
    wait_done("fair", 60);
    chk("fair_ack_count", ack_cyc.size() - n0, 5);
    if (ack_cyc.size() - n0 == 5) begin
      chk("fair_first_lat", ack_cyc[n0] - c0, 3);
      for (int k = 1; k < 5; k++) chk("fair_gap", ack_cyc[n0+k] - ack_cyc[n0+k-1], 3);
    end

    // Single load, cycle-exact latency
    raddr[1] = 3; rdata[1] = 8'hA5;
    push(1, 3, 8'hA5, 0);
    posted[1]++;
    @(negedge CP);
    chk("single_setup_bus_d", 32'(bus.BUS_D), 32'hA5);
    chk("single_setup_reg_cp", 32'(bus.REG_CP), 0);
    chk("single_setup_busy", 32'(bus.BUSY), 1);
    @(negedge CP);
    chk("single_strobe_reg_cp", 32'(bus.REG_CP), 32'h08);
    chk("single_strobe_bus_d", 32'(bus.BUS_D), 32'hA5);
    @(negedge CP);
    chk("single_hold_ack", 32'(bus.ACK), 32'h2);
    chk("single_hold_reg_cp", 32'(bus.REG_CP), 0);
    @(negedge CP);
    chk("single_model_r3", 32'(model[3]), 32'hA5);
    chk("single_idle_busy", 32'(bus.BUSY), 0);
    repeat (2) @(negedge CP);

    // Out-of-range addresses with NUM_REG = 6
    for (int a = 6; a < 8; a++) begin
      raddr[3] = AW'(a); rdata[3] = 8'h5A;
      push(3, AW'(a), 8'h5A, 1);
      posted[3]++;
      wait_done("oor", 20);
    end
    chk("oor_model_r3_kept", 32'(model[3]), 32'hA5);

    // Clear raised while the first load is in SETUP; second requester queued
    raddr[2] = 4; rdata[2] = 8'h3C; push(2, 4, 8'h3C, 0);
    raddr[0] = 5; rdata[0] = 8'h77; push(0, 5, 8'h77, 0);
    c0 = cycle;
    posted[2]++;
    @(negedge CP);
    bus.CLR = 1'b1;
    posted[0]++;
    @(negedge CP);
    bus.CLR = 1'b0;
    n = 0;
    while (bus.N_REG_MR && n < 20) begin @(negedge CP); n++; end
    chk("clr_seen", 32'(bus.N_REG_MR), 0);
    chk("clr_latency", cycle - c0, 5);
    chk("clr_after_ack", 32'(acked[2] == posted[2]), 1);
    chk("clr_before_queued", 32'(acked[0] != posted[0]), 1);
    @(negedge CP);
    chk("clr_one_cycle", 32'(bus.N_REG_MR), 1);
    chk("clr_model_r3", 32'(model[3]), 0);
    chk("clr_model_r4", 32'(model[4]), 0);
    wait_done("clr_queued", 20);
    chk("clr_queued_model_r5", 32'(model[5]), 32'h77);

    // Reset asserted during STROBE abandons the load
    raddr[2] = 1; rdata[2] = 8'h11;
    posted[2]++;
    n = 0;
    while (bus.REG_CP == '0 && n < 20) begin @(negedge CP); n++; end
    chk("mr_strobe_seen", 32'(bus.REG_CP), 32'h02);
    MR = 1'b1;
    @(negedge CP);
    chk("mr_reg_cp", 32'(bus.REG_CP), 0);
    chk("mr_ack", 32'(bus.ACK), 0);
    chk("mr_n_reg_mr", 32'(bus.N_REG_MR), 0);
    chk("mr_busy", 32'(bus.BUSY), 0);
    posted[2] = posted[2] - 1;
    MR = 1'b0;
    @(negedge CP);
    chk("mr_rel_n_reg_mr", 32'(bus.N_REG_MR), 1);
    chk("mr_model_r1", 32'(model[1]), 0);

    // Pointer back at 0: requester 0 must beat requester 3
    raddr[0] = 0; rdata[0] = 8'hC3; push(0, 0, 8'hC3, 0);
    raddr[3] = 2; rdata[3] = 8'h3C; push(3, 2, 8'h3C, 0);
    posted[0]++; posted[3]++;
    wait_done("ptr", 30);
    chk("ptr_model_r0", 32'(model[0]), 32'hC3);
    chk("ptr_model_r2", 32'(model[2]), 32'h3C);

    repeat (3) @(negedge CP);
    chk("scoreboard_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
